// File: rtl/instr_feeder.sv
// instr_feeder: loadable program memory plus program counter that feeds the
// processor one 16-bit instruction at a time, paced by the processor's done pulse.
// Optional watchdog: define INSTR_FEEDER_WDOG_EN to fault and halt when done
// does not arrive within TIMEOUT cycles of WAIT; otherwise fault is tied low.
module instr_feeder #(
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned AW      = 4,
   parameter logic [15:0] HALT_OP = 16'hFFFF,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          load_en,
   input  logic [AW-1:0] load_addr,
   input  logic [15:0]   load_data,
   input  logic          start,
   input  logic          done,
   output logic [15:0]   iin,
   output logic          iin_valid,
   output logic [AW-1:0] pc,
   output logic          running,
   output logic          halted,
   output logic          fault
);

   // Parameter sanity checks at elaboration
   if (DEPTH != (1 << AW)) begin : g_bad_depth
      $error("instr_feeder: DEPTH must equal 2**AW");
   end
   if (DEPTH < 2) begin : g_small_depth
      $error("instr_feeder: DEPTH must be at least 2");
   end
   if (TIMEOUT == 0) begin : g_bad_timeout
      $error("instr_feeder: TIMEOUT must be nonzero");
   end

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      ISSUE = 3'd2,
      WAIT  = 3'd3,
      HALT  = 3'd4
   } state_t;

   localparam logic [AW-1:0] LAST_PC = AW'(DEPTH - 1);

   state_t      state;
   logic [15:0] mem [DEPTH];
   logic [15:0] rd_word;
   logic        loadable;

   assign rd_word  = mem[pc];
   assign loadable = (state == IDLE) || (state == HALT);

`ifdef INSTR_FEEDER_WDOG_EN
   localparam int unsigned CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] wd_cnt;
`else
   assign fault = 1'b0;
`endif

   // Program memory write port; loads are only accepted while not running
   always_ff @(posedge clock) begin
      if (load_en && loadable) begin
         mem[load_addr] <= load_data;
      end
   end

   // Fetch/issue/wait sequencer with registered outputs
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         pc        <= '0;
         iin       <= '0;
         iin_valid <= 1'b0;
         running   <= 1'b0;
         halted    <= 1'b0;
`ifdef INSTR_FEEDER_WDOG_EN
         fault     <= 1'b0;
         wd_cnt    <= '0;
`endif
      end else begin
         iin_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state   <= FETCH;
                  pc      <= '0;
                  running <= 1'b1;
               end
            end
            FETCH: begin
               if (rd_word == HALT_OP) begin
                  state   <= HALT;
                  running <= 1'b0;
                  halted  <= 1'b1;
               end else begin
                  iin       <= rd_word;
                  iin_valid <= 1'b1;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               state <= WAIT;
`ifdef INSTR_FEEDER_WDOG_EN
               wd_cnt <= '0;
`endif
            end
            WAIT: begin
               if (done) begin
                  if (pc == LAST_PC) begin
                     state   <= HALT;
                     running <= 1'b0;
                     halted  <= 1'b1;
                  end else begin
                     pc    <= pc + AW'(1);
                     state <= FETCH;
                  end
               end
`ifdef INSTR_FEEDER_WDOG_EN
               else if (wd_cnt == CW'(TIMEOUT - 1)) begin
                  fault   <= 1'b1;
                  state   <= HALT;
                  running <= 1'b0;
                  halted  <= 1'b1;
               end else begin
                  wd_cnt <= wd_cnt + CW'(1);
               end
`endif
            end
            HALT: begin
               if (start) begin
                  state   <= FETCH;
                  pc      <= '0;
                  running <= 1'b1;
                  halted  <= 1'b0;
`ifdef INSTR_FEEDER_WDOG_EN
                  fault   <= 1'b0;
`endif
               end
            end
            default: begin
               state   <= IDLE;
               running <= 1'b0;
               halted  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_feeder.sv
// Scoreboard bench for instr_feeder: expected issues are queued by the stimulus
// thread and checked by a monitor whenever iin_valid pulses.
module tb_instr_feeder;

   localparam int unsigned AW = 4;

   logic          clock = 1'b0;
   logic          reset;
   logic          load_en;
   logic [AW-1:0] load_addr;
   logic [15:0]   load_data;
   logic          start;
   logic          done;
   logic [15:0]   iin;
   logic          iin_valid;
   logic [AW-1:0] pc;
   logic          running;
   logic          halted;
   logic          fault;

   logic man_done;
   logic auto_pulse;
   bit   auto_done;

   assign done = man_done | auto_pulse;

   instr_feeder #(.DEPTH(16), .AW(AW), .HALT_OP(16'hFFFF), .TIMEOUT(8)) dut (
      .clock(clock), .reset(reset), .load_en(load_en), .load_addr(load_addr),
      .load_data(load_data), .start(start), .done(done), .iin(iin),
      .iin_valid(iin_valid), .pc(pc), .running(running), .halted(halted),
      .fault(fault)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [15:0]   w;
      logic [AW-1:0] p;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   passes = 0;
   int   issues = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic push(input logic [15:0] w, input logic [AW-1:0] p);
      exp_t e;
      e.w = w;
      e.p = p;
      q.push_back(e);
   endtask

   // Monitor: every issue must match the head of the expectation queue
   always @(negedge clock) begin
      if (!reset && iin_valid) begin
         issues++;
         if (q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_issue: got iin %0h pc %0d expected none", iin, pc);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("iin", 32'(iin), 32'(e.w));
            chk("issue_pc", 32'(pc), 32'(e.p));
         end
      end
   end

   // Responder: answers each issue with done three cycles later
   always begin
      @(negedge clock);
      if (auto_done && iin_valid && !reset) begin
         repeat (3) @(posedge clock);
         #1 auto_pulse = 1'b1;
         @(posedge clock);
         #1 auto_pulse = 1'b0;
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic load(input logic [AW-1:0] a, input logic [15:0] d);
      load_en   = 1'b1;
      load_addr = a;
      load_data = d;
      step();
      load_en   = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic pulse_done();
      man_done = 1'b1;
      step();
      man_done = 1'b0;
   endtask

   task automatic wait_halt(input int budget);
      int n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!halted && n < budget);
      chk("wait_halt", 32'(halted), 32'd1);
      step();
   endtask

   task automatic wait_issue(input int budget);
      int n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!iin_valid && n < budget);
      chk("wait_issue", 32'(iin_valid), 32'd1);
   endtask

   initial begin
      int base;
      reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
      start = 1'b0; man_done = 1'b0; auto_pulse = 1'b0; auto_done = 1'b0;
      step(); step();
      reset = 1'b0;
      @(negedge clock);
      chk("rst_pc", 32'(pc), 32'd0);
      chk("rst_iin", 32'(iin), 32'd0);
      chk("rst_valid", 32'(iin_valid), 32'd0);
      chk("rst_running", 32'(running), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_fault", 32'(fault), 32'd0);
      step();

      // Short program ending in HALT_OP
      load(4'd0, 16'hA00A); load(4'd1, 16'hA405); load(4'd2, 16'h0840);
      load(4'd3, 16'h8800); load(4'd4, 16'hFFFF);
      push(16'hA00A, 4'd0); push(16'hA405, 4'd1); push(16'h0840, 4'd2); push(16'h8800, 4'd3);
      base = issues;
      auto_done = 1'b1;
      pulse_start();
      @(negedge clock);
      chk("lat_cycle1", 32'(iin_valid), 32'd0);
      @(negedge clock);
      chk("lat_cycle2", 32'(iin_valid), 32'd1);
      wait_halt(200);
      chk("t1_issues", 32'(issues - base), 32'd4);
      chk("t1_pc", 32'(pc), 32'd4);
      chk("t1_running", 32'(running), 32'd0);

      // Full memory without HALT_OP: stops at the last word, no wrap
      for (int i = 0; i < 16; i++) begin
         load(AW'(i), 16'h0840);
         push(16'h0840, AW'(i));
      end
      base = issues;
      pulse_start();
      wait_halt(400);
      chk("t2_issues", 32'(issues - base), 32'd16);
      chk("t2_pc", 32'(pc), 32'd15);
      step(); step();
      chk("t2_no_wrap", 32'(issues - base), 32'd16);

      // Stray done in IDLE/FETCH/ISSUE, and a load during WAIT
      auto_done = 1'b0;
      reset = 1'b1; step(); reset = 1'b0;
      base = issues;
      pulse_done();
      @(negedge clock);
      chk("t3_idle_pc", 32'(pc), 32'd0);
      chk("t3_idle_running", 32'(running), 32'd0);
      step();
      load(4'd0, 16'hA00A); load(4'd1, 16'hA405); load(4'd2, 16'hFFFF);
      push(16'hA00A, 4'd0); push(16'hA405, 4'd1);
      pulse_start();
      man_done = 1'b1;
      step();
      step();
      man_done  = 1'b0;
      load_en   = 1'b1; load_addr = 4'd1; load_data = 16'h5555;
      step();
      load_en   = 1'b0;
      @(negedge clock);
      chk("t3_wait_pc", 32'(pc), 32'd0);
      chk("t3_wait_running", 32'(running), 32'd1);
      chk("t3_one_issue", 32'(issues - base), 32'd1);
      man_done = 1'b1;
      step();
      man_done  = 1'b0;
      auto_done = 1'b1;
      wait_halt(100);
      chk("t3_halt_pc", 32'(pc), 32'd2);
      push(16'hA00A, 4'd0); push(16'hA405, 4'd1);
      pulse_start();
      wait_halt(100);
      chk("t3_total_issues", 32'(issues - base), 32'd4);

      // Reset while in WAIT at pc 2
      auto_done = 1'b0;
      load(4'd2, 16'h0840); load(4'd3, 16'hFFFF);
      push(16'hA00A, 4'd0); push(16'hA405, 4'd1); push(16'h0840, 4'd2);
      pulse_start();
      wait_issue(20); step(); pulse_done();
      wait_issue(20); step(); pulse_done();
      wait_issue(20);
      chk("t4_pre_pc", 32'(pc), 32'd2);
      step();
      reset = 1'b1; man_done = 1'b1;
      step();
      reset = 1'b0; man_done = 1'b0;
      @(negedge clock);
      chk("t4_pc", 32'(pc), 32'd0);
      chk("t4_valid", 32'(iin_valid), 32'd0);
      chk("t4_running", 32'(running), 32'd0);
      @(negedge clock);
      chk("t4_stays_idle", 32'(running), 32'd0);
      step();
      base = issues;
      push(16'hA00A, 4'd0); push(16'hA405, 4'd1); push(16'h0840, 4'd2);
      auto_done = 1'b1;
      pulse_start();
      wait_halt(200);
      chk("t4_issues", 32'(issues - base), 32'd3);
      chk("t4_halt_pc", 32'(pc), 32'd3);

      // start with a same-cycle write of HALT_OP to address 0
      auto_done = 1'b0;
      base = issues;
      start = 1'b1; load_en = 1'b1; load_addr = 4'd0; load_data = 16'hFFFF;
      step();
      start = 1'b0; load_en = 1'b0;
      @(negedge clock);
      chk("t5_fetch_running", 32'(running), 32'd1);
      chk("t5_fetch_halted", 32'(halted), 32'd0);
      @(negedge clock);
      chk("t5_halted", 32'(halted), 32'd1);
      chk("t5_pc", 32'(pc), 32'd0);
      step(); step();
      chk("t5_no_issue", 32'(issues - base), 32'd0);

      load(4'd0, 16'hA00A);
`ifdef INSTR_FEEDER_WDOG_EN
      // Watchdog: no done -> fault and halt 8 cycles after entering WAIT
      push(16'hA00A, 4'd0);
      pulse_start();
      wait_issue(20);
      repeat (8) @(negedge clock);
      chk("t6_fault_early", 32'(fault), 32'd0);
      chk("t6_halted_early", 32'(halted), 32'd0);
      @(negedge clock);
      chk("t6_fault", 32'(fault), 32'd1);
      chk("t6_halted", 32'(halted), 32'd1);
      step();
      push(16'hA00A, 4'd0);
      pulse_start();
      @(negedge clock);
      chk("t6_fault_cleared", 32'(fault), 32'd0);
      wait_halt(100);
`else
      // Without the watchdog WAIT lasts as long as done is withheld
      push(16'hA00A, 4'd0); push(16'hA405, 4'd1); push(16'h0840, 4'd2);
      pulse_start();
      wait_issue(20);
      repeat (100) @(negedge clock);
      chk("t6_still_running", 32'(running), 32'd1);
      chk("t6_not_halted", 32'(halted), 32'd0);
      chk("t6_no_fault", 32'(fault), 32'd0);
      step();
      pulse_done();
      auto_done = 1'b1;
      wait_halt(200);
      chk("t6_halt_pc", 32'(pc), 32'd3);
`endif
      auto_done = 1'b0;
      step(); step();
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   // Absolute time limit so the bench always terminates
   initial begin
      #200000;
      $display("FAIL timeout: got no completion expected finish before limit");
      $fatal(1, "simulation time limit");
   end

endmodule
